// File: rtl/pmem_arb_types.sv
// Shared types for the physical-memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pmem_arb_types;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    SERVE_P = 2'd3
  } arb_state_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Shares one pmem port among I-cache, D-cache and prefetcher; priority D > I > P with an I starvation guard.
// Latency: one cycle from request (seen in IDLE) to downstream strobe; completion passes through combinationally.
// Backpressure: a grant is held until pmem_resp, then one IDLE bubble precedes the next arbitration.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   i_pmem_*              - I-cache read port
//   d_pmem_*              - D-cache read/write port
//   p_pmem_*              - prefetcher read port
//   pmem_*                - downstream memory port; pmem_rdata is broadcast to every requester
module pmem_arbiter
  import pmem_arb_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic              i_pmem_read,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  input  logic [ADDR_W-1:0] p_pmem_address,
  input  logic              p_pmem_read,
  output logic [LINE_W-1:0] p_pmem_rdata,
  output logic              p_pmem_resp,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  arb_state_t state_q, state_d;
  logic [3:0] d_streak_q, d_streak_d;
  logic       i_req, d_req;

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign p_pmem_rdata = pmem_rdata;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_comb begin
    state_d      = state_q;
    d_streak_d   = d_streak_q;
    pmem_address = '0;
    pmem_wdata   = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    p_pmem_resp  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req && (d_streak_q == STREAK_MAX)) begin
          // I has watched STARVE_LIMIT D grants go by; it goes next.
          state_d    = SERVE_I;
          d_streak_d = '0;
        end else if (d_req) begin
          state_d = SERVE_D;
          // Only D grants that overtake a waiting I count toward starvation.
          if (i_req) begin
            d_streak_d = (d_streak_q >= STREAK_MAX) ? STREAK_MAX : d_streak_q + 4'd1;
          end else begin
            d_streak_d = '0;
          end
        end else if (i_req) begin
          state_d    = SERVE_I;
          d_streak_d = '0;
        end else if (p_pmem_read) begin
          state_d = SERVE_P;
        end
      end

      SERVE_I: begin
        pmem_address = i_pmem_address;
        pmem_read    = i_pmem_read;
        i_pmem_resp  = pmem_resp;
        if (pmem_resp) state_d = IDLE;
      end

      SERVE_D: begin
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        // A simultaneous read+write is treated as a write.
        pmem_write   = d_pmem_write;
        pmem_read    = d_pmem_read & ~d_pmem_write;
        d_pmem_resp  = pmem_resp;
        if (pmem_resp) state_d = IDLE;
      end

      SERVE_P: begin
        // Strobe follows the live request; the grant itself is held until pmem_resp.
        pmem_address = p_pmem_address;
        pmem_read    = p_pmem_read;
        p_pmem_resp  = pmem_resp;
        if (pmem_resp) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      d_streak_q <= '0;
    end else begin
      state_q    <= state_d;
      d_streak_q <= d_streak_d;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus a randomized run against a behavioural model.
// Latency: inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Backpressure: a bench-side downstream responder answers each transaction after a configurable latency.
module tb_pmem_arbiter;

  localparam int STARVE = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [15:0]  i_pmem_address = '0;
  logic         i_pmem_read = 1'b0;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic [15:0]  d_pmem_address = '0;
  logic [127:0] d_pmem_wdata = '0;
  logic         d_pmem_read = 1'b0;
  logic         d_pmem_write = 1'b0;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic [15:0]  p_pmem_address = '0;
  logic         p_pmem_read = 1'b0;
  logic [127:0] p_pmem_rdata;
  logic         p_pmem_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  int checks = 0;
  int failures = 0;

  pmem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .p_pmem_address(p_pmem_address), .p_pmem_read(p_pmem_read),
    .p_pmem_rdata(p_pmem_rdata), .p_pmem_resp(p_pmem_resp),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // Downstream memory: starts counting on the first visible strobe, answers after r_lat cycles.
  int lat_cfg = 3;  // 0 selects a random latency 1..4 per transaction
  int r_lat = 1;
  int r_cnt = 0;
  bit r_busy = 1'b0;
  always @(posedge clk) begin
    #2;
    pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (reset) begin
      r_busy = 1'b0;
      pmem_resp = 1'b0;
    end else if (pmem_resp) begin
      pmem_resp = 1'b0;
      r_busy = 1'b0;
    end else if (r_busy) begin
      r_cnt++;
      if (r_cnt >= r_lat) pmem_resp = 1'b1;
    end else if (pmem_read || pmem_write) begin
      r_busy = 1'b1;
      r_cnt = 0;
      r_lat = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
    end
  end

  // Reference model: who owns the port (0 none, 1 I, 2 D, 3 P) and how many D grants overtook a waiting I.
  int m_owner = 0;
  int m_streak = 0;
  always @(posedge clk) begin
    if (reset) begin
      m_owner = 0;
      m_streak = 0;
    end else if (m_owner != 0) begin
      if (pmem_resp) m_owner = 0;
    end else if (i_pmem_read && m_streak == STARVE) begin
      m_owner = 1;
      m_streak = 0;
    end else if (d_pmem_read || d_pmem_write) begin
      m_owner = 2;
      m_streak = i_pmem_read ? ((m_streak + 1 > STARVE) ? STARVE : m_streak + 1) : 0;
    end else if (i_pmem_read) begin
      m_owner = 1;
      m_streak = 0;
    end else if (p_pmem_read) begin
      m_owner = 3;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  bit mon_en = 1'b0;
  logic [4:0]   e_ctl;
  logic [15:0]  e_addr;
  logic [127:0] e_wdata;
  always @(negedge clk) begin
    if (mon_en) begin
      e_ctl = '0;
      e_addr = '0;
      e_wdata = '0;
      if (m_owner == 1) begin
        e_addr = i_pmem_address;
        e_ctl = {i_pmem_read, 1'b0, pmem_resp, 1'b0, 1'b0};
      end else if (m_owner == 2) begin
        e_addr = d_pmem_address;
        e_wdata = d_pmem_wdata;
        e_ctl = {d_pmem_read && !d_pmem_write, d_pmem_write, 1'b0, pmem_resp, 1'b0};
      end else if (m_owner == 3) begin
        e_addr = p_pmem_address;
        e_ctl = {p_pmem_read, 1'b0, 1'b0, 1'b0, pmem_resp};
      end
      checks++;
      if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, p_pmem_resp} !== e_ctl) begin
        failures++;
        $display("FAIL monitor_ctl t=%0t rd/wr/ir/dr/pr got %b want %b", $time,
                 {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, p_pmem_resp}, e_ctl);
      end
      checks++;
      if (pmem_address !== e_addr) begin
        failures++;
        $display("FAIL monitor_addr t=%0t got %h want %h", $time, pmem_address, e_addr);
      end
      checks++;
      if (pmem_wdata !== e_wdata) begin
        failures++;
        $display("FAIL monitor_wdata t=%0t got %h want %h", $time, pmem_wdata, e_wdata);
      end
      checks++;
      if (i_pmem_rdata !== pmem_rdata || d_pmem_rdata !== pmem_rdata || p_pmem_rdata !== pmem_rdata) begin
        failures++;
        $display("FAIL monitor_rdata t=%0t got %h/%h/%h want %h", $time,
                 i_pmem_rdata, d_pmem_rdata, p_pmem_rdata, pmem_rdata);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
    d_pmem_write = 1'b0;
    p_pmem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      reset = 1'b1;
      i_pmem_read = 1'($urandom);
      d_pmem_read = 1'($urandom);
      d_pmem_write = 1'($urandom);
      p_pmem_read = 1'($urandom);
      i_pmem_address = 16'($urandom);
      d_pmem_address = 16'($urandom);
      @(negedge clk);
      checks++;
      if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, p_pmem_resp} !== 5'b0 ||
          pmem_address !== 16'h0 || pmem_wdata !== 128'h0) begin
        failures++;
        $display("FAIL reset_outputs ctl=%b addr=%h wdata=%h want all zero",
                 {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, p_pmem_resp}, pmem_address, pmem_wdata);
      end
      @(posedge clk); #1;
    end
    do_reset();
  endtask

  task automatic test_single_i();
    int strobe_c = -1;
    int resp_c = -1;
    int other = 0;
    logic [15:0] addr_at = '0;
    do_reset();
    lat_cfg = 3;
    i_pmem_address = 16'h1230;
    i_pmem_read = 1'b1;
    for (int c = 0; c < 20 && resp_c < 0; c++) begin
      @(negedge clk);
      if (pmem_read && strobe_c < 0) begin
        strobe_c = c;
        addr_at = pmem_address;
      end
      if (i_pmem_resp && resp_c < 0) resp_c = c;
      if (d_pmem_resp || p_pmem_resp) other++;
      @(posedge clk); #1;
    end
    i_pmem_read = 1'b0;
    checks++;
    if (strobe_c != 1) begin failures++; $display("FAIL single_i_strobe_cycle got %0d want 1", strobe_c); end
    checks++;
    if (addr_at !== 16'h1230) begin failures++; $display("FAIL single_i_addr got %h want 1230", addr_at); end
    checks++;
    if (resp_c != 4) begin failures++; $display("FAIL single_i_resp_cycle got %0d want 4", resp_c); end
    checks++;
    if (other != 0) begin failures++; $display("FAIL single_i_other_resp got %0d want 0", other); end
  endtask

  task automatic test_all_three();
    int order = 0;
    int n = 0;
    int start_c[3];
    int resp_c[3];
    bit in_txn = 1'b0;
    bit first_wr = 1'b0;
    logic [15:0] first_addr = '0;
    logic [127:0] first_wdata = '0;
    int who;
    do_reset();
    lat_cfg = 0;
    for (int k = 0; k < 3; k++) begin start_c[k] = -1; resp_c[k] = -1; end
    d_pmem_address = 16'h4440;
    d_pmem_wdata = {16{8'hA5}};
    d_pmem_write = 1'b1;
    i_pmem_address = 16'($urandom);
    i_pmem_read = 1'b1;
    p_pmem_address = 16'($urandom);
    p_pmem_read = 1'b1;
    for (int c = 0; c < 60 && n < 3; c++) begin
      who = 0;
      @(negedge clk);
      if ((pmem_read || pmem_write) && !in_txn) begin
        in_txn = 1'b1;
        start_c[n] = c;
        if (n == 0) begin
          first_wr = pmem_write;
          first_addr = pmem_address;
          first_wdata = pmem_wdata;
        end
      end
      if (i_pmem_resp) who = 1;
      if (d_pmem_resp) who = 2;
      if (p_pmem_resp) who = 3;
      if (who != 0) begin
        order = order * 4 + who;
        resp_c[n] = c;
        n++;
        in_txn = 1'b0;
      end
      @(posedge clk); #1;
      if (who == 1) i_pmem_read = 1'b0;
      if (who == 2) d_pmem_write = 1'b0;
      if (who == 3) p_pmem_read = 1'b0;
    end
    i_pmem_read = 1'b0; d_pmem_write = 1'b0; p_pmem_read = 1'b0;
    checks++;
    if (order != 2 * 16 + 1 * 4 + 3) begin failures++; $display("FAIL all_three_order got %0d want 39 (D,I,P)", order); end
    checks++;
    if (!first_wr || first_addr !== 16'h4440 || first_wdata !== {16{8'hA5}}) begin
      failures++;
      $display("FAIL all_three_d_write wr=%b addr=%h wdata=%h want 1/4440/a5..", first_wr, first_addr, first_wdata);
    end
    checks++;
    if (start_c[0] != 1) begin failures++; $display("FAIL all_three_first_start got %0d want 1", start_c[0]); end
    checks++;
    if (start_c[1] - resp_c[0] != 2 || start_c[2] - resp_c[1] != 2) begin
      failures++;
      $display("FAIL all_three_bubble gaps %0d %0d want 2 2", start_c[1] - resp_c[0], start_c[2] - resp_c[1]);
    end
  endtask

  task automatic test_starvation();
    int nd = 0;
    bit i_done = 1'b0;
    logic [3:0] streak_at4 = '0;
    do_reset();
    lat_cfg = 0;
    i_pmem_address = 16'($urandom);
    i_pmem_read = 1'b1;
    d_pmem_address = 16'($urandom);
    d_pmem_read = 1'b1;
    for (int c = 0; c < 100 && !i_done; c++) begin
      bit dr;
      @(negedge clk);
      dr = d_pmem_resp;
      if (dr) begin
        nd++;
        if (nd == STARVE) streak_at4 = dut.d_streak_q;
      end
      if (i_pmem_resp) i_done = 1'b1;
      @(posedge clk); #1;
      if (dr) d_pmem_address = 16'($urandom);
    end
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
    checks++;
    if (!i_done || nd != STARVE) begin
      failures++;
      $display("FAIL starvation_d_count i_done=%b d_grants=%0d want 1/%0d", i_done, nd, STARVE);
    end
    checks++;
    if (streak_at4 !== 4'(STARVE)) begin failures++; $display("FAIL starvation_streak_peak got %0d want %0d", streak_at4, STARVE); end
    @(negedge clk);
    checks++;
    if (dut.d_streak_q !== 4'd0) begin failures++; $display("FAIL starvation_streak_clear got %0d want 0", dut.d_streak_q); end
    @(posedge clk); #1;
  endtask

  task automatic test_rw_both();
    int n_resp = 0;
    bit got_wr = 1'b0;
    bit got_rd = 1'b1;
    bit seen = 1'b0;
    do_reset();
    lat_cfg = 0;
    d_pmem_address = 16'($urandom);
    d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
    d_pmem_read = 1'b1;
    d_pmem_write = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bit dr;
      @(negedge clk);
      if ((pmem_read || pmem_write) && !seen) begin
        seen = 1'b1;
        got_wr = pmem_write;
        got_rd = pmem_read;
      end
      dr = d_pmem_resp;
      if (dr) n_resp++;
      @(posedge clk); #1;
      if (dr) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
    end
    checks++;
    if (got_wr !== 1'b1 || got_rd !== 1'b0) begin failures++; $display("FAIL rw_both_strobes wr=%b rd=%b want 1/0", got_wr, got_rd); end
    checks++;
    if (n_resp != 1) begin failures++; $display("FAIL rw_both_resp_count got %0d want 1", n_resp); end
  endtask

  task automatic test_reset_mid();
    int n_dresp = 0;
    int strobe_c = -1;
    int resp_c = -1;
    logic [15:0] addr_at = '0;
    logic [15:0] ia;
    do_reset();
    lat_cfg = 5;
    d_pmem_address = 16'($urandom);
    d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
    d_pmem_write = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (d_pmem_resp) n_dresp++;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    d_pmem_write = 1'b0;
    @(negedge clk);
    if (d_pmem_resp) n_dresp++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, p_pmem_resp} !== 5'b0 ||
        pmem_address !== 16'h0 || pmem_wdata !== 128'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs ctl=%b addr=%h wdata=%h want all zero",
               {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, p_pmem_resp}, pmem_address, pmem_wdata);
    end
    @(posedge clk); #1;
    lat_cfg = 2;
    ia = 16'($urandom);
    i_pmem_address = ia;
    i_pmem_read = 1'b1;
    for (int c = 0; c < 15 && resp_c < 0; c++) begin
      @(negedge clk);
      if (pmem_read && strobe_c < 0) begin strobe_c = c; addr_at = pmem_address; end
      if (i_pmem_resp) resp_c = c;
      if (d_pmem_resp) n_dresp++;
      @(posedge clk); #1;
    end
    i_pmem_read = 1'b0;
    checks++;
    if (n_dresp != 0) begin failures++; $display("FAIL reset_mid_d_resp got %0d want 0", n_dresp); end
    checks++;
    if (strobe_c != 1 || addr_at !== ia) begin
      failures++;
      $display("FAIL reset_mid_i_grant cycle=%0d addr=%h want 1/%h", strobe_c, addr_at, ia);
    end
    checks++;
    if (resp_c != 3) begin failures++; $display("FAIL reset_mid_i_resp got %0d want 3", resp_c); end
  endtask

  task automatic test_p_drop();
    int resp_c = -1;
    int glitch = 0;
    int hold = 0;
    bit strobe1 = 1'b0;
    logic [15:0] pa;
    logic [15:0] idle_addr = 16'hffff;
    bit idle_rd = 1'b1;
    do_reset();
    lat_cfg = 4;
    pa = 16'($urandom_range(1, 65535));
    p_pmem_address = pa;
    p_pmem_read = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1) strobe1 = pmem_read && (pmem_address === pa);
      if (c >= 2 && c <= 4 && pmem_address === pa && !pmem_read) hold++;
      if (p_pmem_resp && resp_c < 0) resp_c = c;
      if (i_pmem_resp || d_pmem_resp) glitch++;
      if (c == 6) begin idle_addr = pmem_address; idle_rd = pmem_read; end
      @(posedge clk); #1;
      if (c == 1) p_pmem_read = 1'b0;
    end
    checks++;
    if (!strobe1) begin failures++; $display("FAIL p_drop_grant got 0 want 1"); end
    checks++;
    if (hold != 3) begin failures++; $display("FAIL p_drop_hold cycles got %0d want 3", hold); end
    checks++;
    if (resp_c != 5) begin failures++; $display("FAIL p_drop_resp_cycle got %0d want 5", resp_c); end
    checks++;
    if (glitch != 0) begin failures++; $display("FAIL p_drop_id_glitch got %0d want 0", glitch); end
    checks++;
    if (idle_addr !== 16'h0 || idle_rd !== 1'b0) begin
      failures++;
      $display("FAIL p_drop_idle addr=%h rd=%b want 0000/0", idle_addr, idle_rd);
    end
  endtask

  task automatic test_random();
    bit i_act = 1'b0;
    bit d_act = 1'b0;
    bit p_act = 1'b0;
    bit i_seen, d_seen, p_seen;
    int n_done = 0;
    logic [1:0] rw;
    do_reset();
    lat_cfg = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      i_seen = i_pmem_resp;
      d_seen = d_pmem_resp;
      p_seen = p_pmem_resp;
      n_done += int'(i_seen) + int'(d_seen) + int'(p_seen);
      @(posedge clk); #1;
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; p_pmem_read = 1'b0;
        i_act = 1'b0; d_act = 1'b0; p_act = 1'b0;
      end else begin
        reset = 1'b0;
        if (i_act && i_seen) begin
          i_act = 1'b0; i_pmem_read = 1'b0;
        end else if (!i_act && $urandom_range(0, 3) == 0) begin
          i_act = 1'b1; i_pmem_address = 16'($urandom); i_pmem_read = 1'b1;
        end
        if (d_act && d_seen) begin
          d_act = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        end else if (!d_act && $urandom_range(0, 3) == 0) begin
          rw = 2'($urandom_range(1, 3));
          d_act = 1'b1;
          d_pmem_address = 16'($urandom);
          d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
          d_pmem_read = rw[0];
          d_pmem_write = rw[1];
        end
        if (p_act && p_seen) begin
          p_act = 1'b0; p_pmem_read = 1'b0;
        end else if (p_act && m_owner == 3 && r_busy && $urandom_range(0, 5) == 0) begin
          p_act = 1'b0; p_pmem_read = 1'b0;
        end else if (!p_act && $urandom_range(0, 2) == 0) begin
          p_act = 1'b1; p_pmem_address = 16'($urandom); p_pmem_read = 1'b1;
        end
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.d_streak_q !== 4'(m_streak)) begin
      failures++;
      $display("FAIL random_streak got %0d want %0d", dut.d_streak_q, m_streak);
    end
    checks++;
    if (n_done < 100) begin failures++; $display("FAIL random_progress completions got %0d want >=100", n_done); end
    @(posedge clk); #1;
    do_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    test_reset();
    test_single_i();
    test_all_three();
    test_starvation();
    test_rw_both();
    test_reset_mid();
    test_p_drop();
    test_random();
    repeat (3) begin @(posedge clk); #1; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
